// File: rtl/dm_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state encoding, default geometry/latency, the byte-address
// field ranges and the byte-lane merge helper used for the store log.
package dm_pkg;

  localparam int unsigned DEF_LATENCY     = 2;
  localparam int unsigned DEF_DEPTH_WORDS = 4096;

  // Byte-address fields: word index and the out-of-range upper bits.
  localparam int unsigned WORD_IDX_HI = 13;
  localparam int unsigned WORD_IDX_LO = 2;
  localparam int unsigned OOR_HI      = 31;
  localparam int unsigned OOR_LO      = 14;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Lanes with be[i]=1 come from new_w, the rest keep old_w.
  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word storage for the data memory responder.
// Ports: clk, rst_n (async active-low clear of every word), we_i/be_i/idx_i/
// wdata_i (byte-enabled write at the rising edge), rdata_c_o (asynchronous
// read of word idx_i).
module dm_array
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Byte-lane write; reset clears the whole array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_c_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_resp.sv
// Data memory with a fixed-latency request/response handshake.
// Ports: clk, reset (async active-low); request side req_valid/req_ready,
// req_we, req_be, req_addr, req_wdata, req_pc; response side resp_valid
// (one-cycle pulse), resp_rdata (registered load data, 0 for stores);
// stall (combinational freeze request to the hazard unit).
// Loads complete LATENCY cycles after accept, stores one cycle after accept.
module data_mem_resp
  import dm_pkg::*;
#(
  parameter int unsigned LATENCY     = DEF_LATENCY,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_pc,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;

  logic                idle_c;
  logic                accept_c;
  logic                in_range_c;
  logic                wr_en_c;
  logic [AW-1:0]       word_idx_c;
  logic [DATA_W-1:0]   arr_rdata_c;
  logic [DATA_W-1:0]   merged_c;
  logic                unused_addr_c;

  assign idle_c     = (state_q == IDLE);
  assign accept_c   = req_valid & idle_c;
  assign in_range_c = (req_addr[OOR_HI:OOR_LO] == '0);
  assign word_idx_c = AW'(req_addr[WORD_IDX_HI:WORD_IDX_LO]);
  // Out-of-range and all-lanes-off stores still complete but touch nothing.
  assign wr_en_c    = accept_c & req_we & in_range_c & (|req_be);
  assign merged_c   = merge_be(arr_rdata_c, req_wdata, req_be);
  assign unused_addr_c = ^req_addr[1:0];

  assign req_ready  = idle_c;
  assign stall      = ~idle_c | (req_valid & idle_c);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  dm_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .rst_n     (reset),
    .we_i      (wr_en_c),
    .be_i      (req_be),
    .idx_i     (word_idx_c),
    .wdata_i   (req_wdata),
    .rdata_c_o (arr_rdata_c)
  );

  // Control FSM: response data is captured at accept, the counter only
  // spans the WAIT cycles between accept and the RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            resp_rdata_q <= (!req_we && in_range_c) ? arr_rdata_c : '0;
            if (req_we || LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Store commit log.
  always_ff @(posedge clk) begin
    if (reset && wr_en_c) begin
      $display("@%08h: *%08h <= %08h", req_pc, {req_addr[31:2], 2'b00}, merged_c);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: three instances with LATENCY 2, 1
// and 4; a vector table drives the LATENCY=2 instance, hand-written
// sequences cover back-to-back requests, reset during WAIT and latencies.
module tb_data_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [2:0]       req_valid;
  logic [2:0]       req_we;
  logic [2:0][3:0]  req_be;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0][31:0] req_pc;
  logic [2:0]       req_ready;
  logic [2:0]       resp_valid;
  logic [2:0][31:0] resp_rdata;
  logic [2:0]       stall;

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_be     (req_be[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_pc     (req_pc[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .stall      (stall[g])
    );
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  task automatic idle_inputs(input int k);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_be[k]    = 4'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_pc[k]    = $urandom;
  endtask

  // Called just after the accept edge; returns just after the edge ending
  // the response cycle.
  task automatic wait_resp(input int k, input int exp_lat, input logic [31:0] exp_rd,
                           input string name);
    int          got = 0;
    bit          stall_ok = 1'b1;
    logic [31:0] rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!stall[k]) stall_ok = 1'b0;
      if (resp_valid[k]) begin
        got = c;
        rd  = resp_rdata[k];
        break;
      end
    end
    check_eq({name, " latency"}, 32'(got), 32'(exp_lat));
    check_eq({name, " rdata"}, rd, exp_rd);
    check_eq({name, " stall held"}, 32'(stall_ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int k, input vec_t v, input string name);
    req_valid[k] = 1'b1;
    req_we[k]    = v.we;
    req_be[k]    = v.be;
    req_addr[k]  = v.addr;
    req_wdata[k] = v.wdata;
    req_pc[k]    = v.pc;
    @(negedge clk);
    check_eq({name, " ready/stall at accept"}, {30'd0, req_ready[k], stall[k]}, 32'h3);
    @(posedge clk);
    #1;
    idle_inputs(k);
    wait_resp(k, v.lat, v.rdata, name);
    @(negedge clk);
    check_eq({name, " idle after resp"}, {29'd0, req_ready[k], stall[k], resp_valid[k]}, 32'h4);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
    vec_t v;
    v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.pc = 32'h3000 + addr; v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    bit   saw_rv;

    // Vector table for the LATENCY=2 instance (memory starts cleared).
    vecs[0]  = mk(1'b1, 4'b1111, 32'h0000_0010, 32'h1234_5678, 32'h0, 1);
    vecs[0].pc = 32'h0000_3000;
    vecs[1]  = mk(1'b1, 4'b0010, 32'h0000_0011, 32'h0000_AB00, 32'h0, 1);
    vecs[2]  = mk(1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'h1234_AB78, 2);
    vecs[3]  = mk(1'b0, 4'b1111, 32'h0000_4000, 32'h0,         32'h0, 2);
    vecs[4]  = mk(1'b1, 4'b1111, 32'h0000_4010, 32'hDEAD_BEEF, 32'h0, 1);
    vecs[5]  = mk(1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'h1234_AB78, 2);
    vecs[6]  = mk(1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 1);
    vecs[7]  = mk(1'b0, 4'b0000, 32'h0000_0013, 32'h0,         32'h1234_AB78, 2);
    vecs[8]  = mk(1'b1, 4'b1001, 32'h0000_3FFC, 32'hA5A5_A5A5, 32'h0, 1);
    vecs[9]  = mk(1'b0, 4'b0000, 32'h0000_3FFC, 32'h0,         32'hA500_00A5, 2);
    vecs[10] = mk(1'b0, 4'b0000, 32'h0000_0000, 32'h0,         32'h0, 2);
    vecs[11] = mk(1'b1, 4'b1100, 32'h0000_0013, 32'h1122_3344, 32'h0, 1);
    vecs[12] = mk(1'b0, 4'b0000, 32'h0000_0012, 32'h0,         32'h1122_AB78, 2);
    vecs[13] = mk(1'b1, 4'b1111, 32'h0000_0004, 32'h0BAD_F00D, 32'h0, 1);
    vecs[14] = mk(1'b1, 4'b1111, 32'h0000_0000, 32'h00C0_FFEE, 32'h0, 1);

    reset = 1'b0;
    for (int k = 0; k < 3; k++) idle_inputs(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("reset state dut%0d", k),
               {req_ready[k], resp_valid[k], 30'd0} | {2'b00, resp_rdata[k][29:0]} |
               (resp_rdata[k] & 32'hC000_0000), 32'h8000_0000);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready first cycle after reset", {31'd0, req_ready[0]}, 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      do_req(0, vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back loads with req_valid held high.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_be[0] = 4'hF;
    req_addr[0] = 32'h0; req_wdata[0] = 32'h0; req_pc[0] = 32'h0;
    @(negedge clk);
    check_eq("b2b first accept", {30'd0, req_ready[0], stall[0]}, 32'h3);
    @(posedge clk);
    #1;
    req_addr[0] = 32'h4;
    wait_resp(0, 2, 32'h00C0_FFEE, "b2b first");
    @(negedge clk);
    check_eq("b2b second accept", {30'd0, req_ready[0], stall[0]}, 32'h3);
    @(posedge clk);
    #1;
    idle_inputs(0);
    wait_resp(0, 2, 32'h0BAD_F00D, "b2b second");
    @(negedge clk);
    check_eq("b2b idle after", {29'd0, req_ready[0], stall[0], resp_valid[0]}, 32'h4);
    @(posedge clk);
    #1;

    // Reset asserted while a load sits in WAIT.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    @(posedge clk);
    #1;
    idle_inputs(0);
    reset = 1'b0;
    #1;
    check_eq("reset mid-wait outputs",
             {29'd0, req_ready[0], resp_valid[0], |resp_rdata[0]}, 32'h4);
    saw_rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid[0]) saw_rv = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    if (resp_valid[0]) saw_rv = 1'b1;
    check_eq("ready after mid-wait reset", {31'd0, req_ready[0]}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      if (resp_valid[0]) saw_rv = 1'b1;
    end
    check_eq("no resp_valid after abort", {31'd0, saw_rv}, 32'h0);
    @(posedge clk);
    #1;
    v = mk(1'b0, 4'b0000, 32'h10, 32'h0, 32'h0, 2);
    do_req(0, v, "load 0x10 after reset");
    v = mk(1'b0, 4'b0000, 32'h3FFC, 32'h0, 32'h0, 2);
    do_req(0, v, "load 0x3FFC after reset");

    // Store/merge/load sequence at LATENCY=1 and LATENCY=4.
    for (int k = 1; k < 3; k++) begin
      v = mk(1'b1, 4'b1111, 32'h10, 32'h1234_5678, 32'h0, 1);
      do_req(k, v, $sformatf("lat dut%0d sw", k));
      v = mk(1'b1, 4'b0010, 32'h11, 32'h0000_AB00, 32'h0, 1);
      do_req(k, v, $sformatf("lat dut%0d sb", k));
      v = mk(1'b0, 4'b0000, 32'h10, 32'h0, 32'h1234_AB78, (k == 1) ? 1 : 4);
      do_req(k, v, $sformatf("lat dut%0d lw", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning read latency in cycles from accept to resp_valid (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning number of 32-bit words stored (16 KiB, byte addresses 0x0000_0000..0x0000_3FFF).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid, input, 1, initiator (M stage) presents a request.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_be, input, 4, byte enables for stores (bit i = byte lane i).
REQ-009 SHALL have port req_addr, input, 32, byte address; bits [1:0] ignored.
REQ-010 SHALL have port req_wdata, input, 32, store data, lane-aligned.
REQ-011 SHALL have port req_pc, input, 32, PC of the issuing instruction, used only for the write log.
REQ-012 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 32, load data; 0 for store completions.
REQ-014 SHALL have port stall, output, 1, freeze request to the hazard unit.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready.
REQ-017 stall SHALL equal (state != IDLE) | (req_valid & state == IDLE), i.e. the pipeline holds until the cycle after resp_valid.
REQ-018 Load accepted in cycle n: IDLE->WAIT (or ->RESP if LATENCY=1), a 4-bit counter counts down, resp_valid=1 exactly in cycle n+LATENCY.
REQ-019 Load data SHALL be the word at req_addr[13:2], captured at accept into a registered resp_rdata, held stable while resp_valid=1.
REQ-020 Store accepted in cycle n: lanes with req_be[i]=1 are written at the end of cycle n, other lanes unchanged, IDLE->RESP, resp_valid=1 in cycle n+1, regardless of LATENCY.
REQ-021 On every committed store, SHALL print "@<req_pc>: *<word addr, low 2 bits 0> <= <merged 32-bit word>" (hex, 8 digits each).
REQ-022 req_addr[31:14] != 0 (out of range): store SHALL not modify memory and not print; load SHALL return 0; completion timing unchanged.
REQ-023 Store with req_be=4'b0000 SHALL complete normally with no memory change and no print.
REQ-024 RESP SHALL always return to IDLE on the next cycle; a request held valid during WAIT/RESP is accepted in the first IDLE cycle (cycle after resp_valid).
REQ-025 Inputs other than req_valid SHALL be ignored outside the accept cycle.
REQ-026 A store followed by a load to the same word SHALL return the merged stored value.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, and all memory words to 0.
REQ-028 reset asserted mid-operation SHALL abort it with no resp_valid; a store already committed stays committed only if its accept edge preceded reset assertion.
REQ-029 After reset release, req_ready=1 in the first cycle.

Structure
REQ-030 Package dm_pkg SHALL hold the state enum, default LATENCY/DEPTH_WORDS, and the address field ranges (word index [13:2], out-of-range [31:14]).
REQ-031 A sub-module dm_array SHALL hold the word storage with byte-enable write and asynchronous clear; FSM, counter, and logging stay in data_mem_resp.

Verification
REQ-032 Store 0x12345678, be=1111, addr=0x10, pc=0x3000 -> resp_valid in cycle n+1, log "@00003000: *00000010 <= 12345678".
REQ-033 Then sb-style store be=0010, wdata=0x0000AB00, addr=0x11 -> log word 0x1234AB78; load addr=0x10 -> resp_rdata 0x1234AB78 exactly LATENCY cycles after accept.
REQ-034 Load 0x4000 (out of range) -> resp_rdata 0, no log; store to 0x4000 -> no log, memory unchanged.
REQ-035 req_valid held high for back-to-back loads at 0x0,0x4 -> second accept in the cycle after first resp_valid; stall high continuously until then.
REQ-036 reset=0 during WAIT -> resp_valid never pulses, req_ready=1 after release, load of 0x10 returns 0.
REQ-037 Repeat REQ-033 with LATENCY=1 and LATENCY=4 -> resp_valid at n+1 and n+4 respectively.
